// File: rtl/collatz_responder_pkg.sv
// collatz_responder_pkg: shared state encodings and default word width
package collatz_responder_pkg;

    localparam int INT_N = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } state_t;

endpackage

// File: rtl/collatz_responder_step.sv
// collatz_step: one combinational Collatz step with overflow and termination flags
module collatz_step
    import collatz_responder_pkg::*;
#(
    parameter int N = INT_N
) (
    input  logic [N-1:0] cur,
    output logic [N-1:0] nxt,
    output logic         is_one,
    output logic         ovf
);

    logic [N+1:0] tri3;

    // 3*cur+1 is formed two bits wide so an overflow past N bits is observable
    always_comb begin
        tri3   = {2'b00, cur} + {1'b0, cur, 1'b0} + (N+2)'(1);
        is_one = cur == N'(1);
        ovf    = cur[0] & (|tri3[N+1:N]);
        nxt    = cur[0] ? tri3[N-1:0] : {1'b0, cur[N-1:1]};
    end

endmodule

// File: rtl/collatz_responder.sv
// collatz_responder: request/response responder computing Collatz stopping time, one step per clock
module collatz_responder
    import collatz_responder_pkg::*;
#(
    parameter int N         = INT_N,
    parameter int MAX_STEPS = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_data,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_data,
    output logic         resp_err
);

    localparam logic [N-1:0] MAX_C = N'(MAX_STEPS);

    state_t       state;
    logic [N-1:0] cur;
    logic [N-1:0] cnt;
    logic [N-1:0] nxt;
    logic         is_one;
    logic         ovf;

    collatz_step #(.N(N)) u_step (
        .cur    (cur),
        .nxt    (nxt),
        .is_one (is_one),
        .ovf    (ovf)
    );

    // FSM: accept, iterate until 1/limit/overflow/zero, then hold the response until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur        <= '0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cur       <= req_data;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_RUN;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // a zero start is reported here so every request takes at least one RUN cycle;
                    // in every terminating case the reported data is the steps completed so far
                    if (cur == '0 || is_one || cnt == MAX_C || ovf) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= cnt;
                        resp_err   <= !is_one;
                    end else begin
                        cur <= nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_responder.sv
// tb_collatz_responder: directed scoreboard bench for collatz_responder
module tb_collatz_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv0 = 1'b0;
    logic        rv1 = 1'b0;
    logic [15:0] rd  = '0;
    logic        rr  = 1'b0;
    logic        rq0, rq1, vv0, vv1, er0, er1;
    logic [15:0] d0, d1;
    logic        sel = 1'b0;
    logic        rdy, vld, err;
    logic [15:0] dat;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    collatz_responder dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rq0), .req_data(rd),
        .resp_valid(vv0), .resp_ready(rr), .resp_data(d0), .resp_err(er0)
    );

    collatz_responder #(.MAX_STEPS(10)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rq1), .req_data(rd),
        .resp_valid(vv1), .resp_ready(rr), .resp_data(d1), .resp_err(er1)
    );

    assign rdy = sel ? rq1 : rq0;
    assign vld = sel ? vv1 : vv0;
    assign err = sel ? er1 : er0;
    assign dat = sel ? d1 : d0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input logic s, input logic [15:0] n, input logic [15:0] ed,
                       input logic ee, input int el, input int hold);
        exp_t e;
        int   lat;
        int   w;
        sel = s;
        sb.push_back('{ed, ee, el});
        w = 0;
        while (!rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", rdy, 1);
        if (s) rv1 = 1'b1; else rv0 = 1'b1;
        rd = n;
        @(posedge clk);
        #1;
        rv0 = 1'b0;
        rv1 = 1'b0;
        rd  = 16'($urandom);
        @(negedge clk);
        chk("ready_low_after_accept", rdy, 0);
        lat = 0;
        while (!vld && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("resp_valid_seen", vld, 1);
        if (!vld) return;
        chk("latency", lat, e.lat);
        chk("resp_data", dat, e.data);
        chk("resp_err", err, e.err);
        chk("ready_low_in_resp", rdy, 0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", vld, 1);
            chk("hold_data", dat, e.data);
            chk("hold_err", err, e.err);
            chk("hold_ready_low", rdy, 0);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        @(negedge clk);
        chk("valid_fall", vld, 0);
        chk("ready_rise", rdy, 1);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {rq0, rq1}, 0);
        chk("rst_resp_valid", {vv0, vv1}, 0);
        chk("rst_resp_data", {d0, d1}, 0);
        chk("rst_resp_err", {er0, er1}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {rq0, rq1}, 2'b11);

        run(0, 16'd27,    16'd111, 0, 112, 0);
        run(0, 16'd1,     16'd0,   0, 1,   0);
        run(0, 16'd0,     16'd0,   1, 1,   0);
        run(0, 16'd21845, 16'd0,   1, 1,   0);
        run(1, 16'd27,    16'd10,  1, 11,  0);
        run(0, 16'd6,     16'd8,   0, 9,   5);
        run(0, 16'd43690, 16'd1,   1, 2,   0);
        run(0, 16'd65535, 16'd0,   1, 1,   0);
        run(0, 16'd7,     16'd16,  0, 17,  2);
        run(1, 16'd3,     16'd7,   0, 8,   0);
        run(0, 16'd2,     16'd1,   0, 2,   0);

        sel = 1'b0;
        rv0 = 1'b1;
        rd  = 16'd27;
        @(posedge clk);
        #1;
        rv0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("running_no_valid", vv0, 0);
        rst = 1'b1;
        #1;
        chk("midrun_rst_ready", rq0, 0);
        chk("midrun_rst_valid", vv0, 0);
        chk("midrun_rst_data", d0, 0);
        chk("midrun_rst_err", er0, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (vv0) seen++;
        end
        chk("no_resp_after_rst", seen, 0);
        run(0, 16'd3, 16'd7, 0, 8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
